// File: rtl/simd_pe_array.sv
// SIMD processing-element array: NUM_PE lanes accumulate a broadcast operand in MAC/MAX/MIN/ADD mode,
// with a two-stage datapath, per-lane saturating snapshot and a ready/valid output holding register.
module simd_pe_array #(
    parameter int NUM_PE     = 8,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+8
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           clr_i,
    input  logic                           we_i,
    input  logic [1:0]                     mode_i,
    input  logic [NUM_PE*DATA_WIDTH-1:0]   srca_word_i,
    input  logic [DATA_WIDTH-1:0]          srcb_i,
    input  logic                           snap_i,
    input  logic                           out_ready_i,
    output logic [NUM_PE*DATA_WIDTH-1:0]   srca_word_o,
    output logic                           clr_o,
    output logic                           we_o,
    output logic [NUM_PE*DATA_WIDTH-1:0]   wordp_o,
    output logic [NUM_PE-1:0]              sat_o,
    output logic                           out_valid_o,
    output logic                           overflow_o
);
    localparam int PW = 2*DATA_WIDTH;
    localparam logic signed [ACC_WIDTH-1:0] LANE_MAX = ACC_WIDTH'((64'sd1 <<< (DATA_WIDTH-1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH-1:0] LANE_MIN = ~LANE_MAX;

    typedef enum logic [1:0] {
        MODE_MAC = 2'b00,
        MODE_MAX = 2'b01,
        MODE_MIN = 2'b10,
        MODE_ADD = 2'b11
    } mode_e;

    // mode_reg is the mode of the sample sitting in stage 1; acc_mode_reg is the mode the
    // accumulators were last cleared into, needed to format a pre-clear snapshot.
    mode_e mode_reg, mode_next, acc_mode_reg;
    logic  s1_clr_reg, s1_we_reg, s1_snap_reg, snap_pend_reg, fmt_mac;
    logic signed [DATA_WIDTH-1:0] srcb_s;

    logic signed [PW-1:0]        s1_op_reg  [NUM_PE];
    logic signed [PW-1:0]        s1_op_next [NUM_PE];
    logic signed [ACC_WIDTH-1:0] acc_reg    [NUM_PE];
    logic signed [ACC_WIDTH-1:0] acc_next   [NUM_PE];
    logic [NUM_PE-1:0]           first_reg, first_next;
    logic [NUM_PE*DATA_WIDTH-1:0] snap_word_reg, snap_word_next;
    logic [NUM_PE-1:0]           snap_sat_reg, snap_sat_next;

    assign mode_next = clr_i ? mode_e'(mode_i) : mode_reg;
    assign srcb_s    = srcb_i;
    assign fmt_mac   = s1_clr_reg ? (acc_mode_reg == MODE_MAC) : (mode_reg == MODE_MAC);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PE; gi++) begin : g_lane
            logic signed [DATA_WIDTH-1:0] a_lane;
            logic signed [PW-1:0]         a_ext, b_ext;
            logic signed [ACC_WIDTH-1:0]  contrib, acc_cur, lane_next, snap_src, scaled;
            logic                         lane_first_next, lane_sat;
            logic [DATA_WIDTH-1:0]        lane_word;

            assign a_lane = srca_word_i[gi*DATA_WIDTH +: DATA_WIDTH];
            assign a_ext  = PW'(a_lane);
            assign b_ext  = PW'(srcb_s);
            assign s1_op_next[gi] = (mode_next == MODE_MAC) ? a_ext * b_ext : a_ext;

            assign acc_cur = acc_reg[gi];
            assign contrib = ACC_WIDTH'(s1_op_reg[gi]);

            always_comb begin
                lane_next       = acc_cur;
                lane_first_next = first_reg[gi];
                if (s1_we_reg) begin
                    lane_first_next = 1'b0;
                    if (s1_clr_reg || first_reg[gi]) begin
                        lane_next = contrib;
                    end else begin
                        case (mode_reg)
                            MODE_MAX: lane_next = (contrib > acc_cur) ? contrib : acc_cur;
                            MODE_MIN: lane_next = (contrib < acc_cur) ? contrib : acc_cur;
                            default:  lane_next = acc_cur + contrib;
                        endcase
                    end
                end else if (s1_clr_reg) begin
                    lane_next       = '0;
                    lane_first_next = 1'b1;
                end
            end

            // A snapshot taken together with a clear reports the accumulation being discarded.
            always_comb begin
                snap_src  = s1_clr_reg ? acc_cur : lane_next;
                scaled    = fmt_mac ? (snap_src >>> FRAC_BITS) : snap_src;
                lane_sat  = 1'b0;
                lane_word = scaled[DATA_WIDTH-1:0];
                if (scaled > LANE_MAX) begin
                    lane_sat  = 1'b1;
                    lane_word = LANE_MAX[DATA_WIDTH-1:0];
                end else if (scaled < LANE_MIN) begin
                    lane_sat  = 1'b1;
                    lane_word = LANE_MIN[DATA_WIDTH-1:0];
                end
            end

            assign acc_next[gi]   = lane_next;
            assign first_next[gi] = lane_first_next;
            assign snap_word_next[gi*DATA_WIDTH +: DATA_WIDTH] = lane_word;
            assign snap_sat_next[gi] = lane_sat;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            srca_word_o   <= '0;
            clr_o         <= 1'b0;
            we_o          <= 1'b0;
            mode_reg      <= MODE_MAC;
            acc_mode_reg  <= MODE_MAC;
            s1_clr_reg    <= 1'b0;
            s1_we_reg     <= 1'b0;
            s1_snap_reg   <= 1'b0;
            snap_pend_reg <= 1'b0;
            first_reg     <= '1;
            snap_word_reg <= '0;
            snap_sat_reg  <= '0;
            wordp_o       <= '0;
            sat_o         <= '0;
            out_valid_o   <= 1'b0;
            overflow_o    <= 1'b0;
            for (int i = 0; i < NUM_PE; i++) begin
                s1_op_reg[i] <= '0;
                acc_reg[i]   <= '0;
            end
        end else begin
            srca_word_o <= srca_word_i;
            clr_o       <= clr_i;
            we_o        <= we_i;
            mode_reg    <= mode_next;
            s1_clr_reg  <= clr_i;
            s1_we_reg   <= we_i;
            s1_snap_reg <= snap_i;
            first_reg   <= first_next;
            for (int i = 0; i < NUM_PE; i++) begin
                s1_op_reg[i] <= s1_op_next[i];
                acc_reg[i]   <= acc_next[i];
            end
            if (s1_clr_reg) begin
                acc_mode_reg <= mode_reg;
            end
            snap_pend_reg <= s1_snap_reg;
            if (s1_snap_reg) begin
                snap_word_reg <= snap_word_next;
                snap_sat_reg  <= snap_sat_next;
            end
            // Output holding register: a new snapshot only lands when the held one is free or leaving.
            if (snap_pend_reg) begin
                if (!out_valid_o || out_ready_i) begin
                    wordp_o     <= snap_word_reg;
                    sat_o       <= snap_sat_reg;
                    out_valid_o <= 1'b1;
                end else begin
                    overflow_o <= 1'b1;
                end
            end else if (out_valid_o && out_ready_i) begin
                out_valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_simd_pe_array.sv
// Scoreboard bench for simd_pe_array: a behavioural lane model queues expected snapshots as
// stimulus is driven; a monitor pops and compares them whenever an output word is accepted.
module tb_simd_pe_array;
    localparam int NP = 8;
    localparam int DW = 16;
    localparam int W  = NP*DW;

    logic          clk, rst_n, clr, we, snap, out_ready;
    logic [1:0]    mode;
    logic [W-1:0]  srca_word, srca_word_d, wordp;
    logic [DW-1:0] srcb;
    logic          clr_d, we_d, out_valid, overflow;
    logic [NP-1:0] sat;

    simd_pe_array #(.NUM_PE(NP), .DATA_WIDTH(DW), .FRAC_BITS(8), .ACC_WIDTH(2*DW+8)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .we_i(we), .mode_i(mode),
        .srca_word_i(srca_word), .srcb_i(srcb), .snap_i(snap), .out_ready_i(out_ready),
        .srca_word_o(srca_word_d), .clr_o(clr_d), .we_o(we_d), .wordp_o(wordp),
        .sat_o(sat), .out_valid_o(out_valid), .overflow_o(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  word;
        logic [NP-1:0] sat;
    } exp_t;

    exp_t    exp_q[$];
    int      n_vec = 0;
    int      n_err = 0;
    longint  m_acc [NP];
    bit      m_first [NP];
    logic [1:0] m_mode;
    bit      drop_next = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic longint wrap40(input longint v);
        return (v <<< 24) >>> 24;
    endfunction

    function automatic exp_t fmt(input logic [1:0] md);
        exp_t   e;
        longint v;
        e.word = '0;
        e.sat  = '0;
        for (int i = 0; i < NP; i++) begin
            v = (md == 2'b00) ? (m_acc[i] >>> 8) : m_acc[i];
            if (v > 32767) begin
                v = 32767;
                e.sat[i] = 1'b1;
            end else if (v < -32768) begin
                v = -32768;
                e.sat[i] = 1'b1;
            end
            e.word[i*DW +: DW] = v[15:0];
        end
        return e;
    endfunction

    function automatic logic [W-1:0] pack(input int v [NP], input int scale);
        logic [W-1:0] w;
        int t;
        w = '0;
        for (int i = 0; i < NP; i++) begin
            t = v[i] * scale;
            w[i*DW +: DW] = t[15:0];
        end
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            m_acc[i]   = 0;
            m_first[i] = 1;
        end
        m_mode = 2'b00;
        exp_q.delete();
    endtask

    // One cycle of stimulus: the model advances in step and queues any snapshot it implies.
    task automatic drive(input bit c, input bit w, input logic [1:0] md,
                         input logic [W-1:0] aw, input logic [DW-1:0] b, input bit s);
        longint a, bb, contrib;
        clr = c; we = w; mode = md; srca_word = aw; srcb = b; snap = s;
        if (s && c && !drop_next) exp_q.push_back(fmt(m_mode));
        if (c) m_mode = md;
        bb = $signed(b);
        for (int i = 0; i < NP; i++) begin
            a = $signed(aw[i*DW +: DW]);
            contrib = (m_mode == 2'b00) ? a * bb : a;
            if (w) begin
                if (c || m_first[i]) m_acc[i] = contrib;
                else case (m_mode)
                    2'b01:   m_acc[i] = (contrib > m_acc[i]) ? contrib : m_acc[i];
                    2'b10:   m_acc[i] = (contrib < m_acc[i]) ? contrib : m_acc[i];
                    default: m_acc[i] = m_acc[i] + contrib;
                endcase
                m_first[i] = 0;
            end else if (c) begin
                m_acc[i]   = 0;
                m_first[i] = 1;
            end
            m_acc[i] = wrap40(m_acc[i]);
        end
        if (s && !c && !drop_next) exp_q.push_back(fmt(m_mode));
        if (s) drop_next = 0;
        @(posedge clk); #1;
        clr = 0; we = 0; snap = 0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic expect_word(input string tag, input logic [W-1:0] w, input logic [NP-1:0] s);
        int n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_valid"}, W'(out_valid), W'(1));
        check(tag, wordp, w);
        check({tag, "_sat"}, W'(sat), W'(s));
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", W'(out_valid), W'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_word", wordp, e.word);
                check("sb_sat", W'(sat), W'(e.sat));
                $display("snapshot accepted: word=%h sat=%h", wordp, sat);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ramp, r1, r2, r3, pos, neg, held;
        rst_n = 0; clr = 0; we = 0; snap = 0; mode = 0; srca_word = '0; srcb = '0; out_ready = 1;
        model_reset();
        ramp = pack('{1, 2, 3, 4, 5, 6, 7, 8}, 256);
        r1   = pack('{5, 3, 9, 2, 7, 1, 4, 8}, 256);
        r2   = pack('{2, 8, 1, 6, 3, 9, 5, 4}, 256);
        r3   = pack('{7, 4, 6, 9, 1, 5, 8, 2}, 256);
        pos  = pack('{127, 127, 127, 127, 127, 127, 127, 127}, 256);
        neg  = pack('{-127, -127, -127, -127, -127, -127, -127, -127}, 256);
        #12;
        check("rst_valid", W'(out_valid), W'(0));
        check("rst_wordp", wordp, '0);
        check("rst_overflow", W'(overflow), W'(0));
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;

        // MAC with latency and explicit lane values
        drive(1, 1, 2'b00, ramp, 16'd256, 0);
        check("delay_srca", srca_word_d, ramp);
        check("delay_clr_we", W'({clr_d, we_d}), W'(2'b11));
        drive(0, 1, 2'b00, ramp, 16'd512, 0);
        drive(0, 1, 2'b00, ramp, 16'd768, 0);
        drive(0, 1, 2'b00, ramp, 16'd1024, 1);
        check("mac_lat1", W'(out_valid), W'(0));
        wait_cycles(1);
        check("mac_lat2", W'(out_valid), W'(0));
        wait_cycles(1);
        check("mac_lat3", W'(out_valid), W'(1));
        for (int i = 0; i < NP; i++) check("mac_lane", W'(wordp[i*DW +: DW]), W'(2560*(i+1)));
        check("mac_sat", W'(sat), W'(0));
        wait_cycles(1);

        // mode_i ignored without clr
        drive(1, 1, 2'b00, ramp, 16'd256, 0);
        drive(0, 1, 2'b01, ramp, 16'd512, 1);
        expect_word("mode_latch", pack('{768, 1536, 2304, 3072, 3840, 4608, 5376, 6144}, 1), '0);

        // MAX and MIN
        drive(1, 1, 2'b01, r1, 16'd0, 0);
        drive(0, 1, 2'b01, r2, 16'd0, 0);
        drive(0, 1, 2'b01, r3, 16'd0, 1);
        expect_word("max", pack('{7, 8, 9, 9, 7, 9, 8, 8}, 256), '0);
        drive(1, 1, 2'b10, r1, 16'd0, 0);
        drive(0, 1, 2'b10, r2, 16'd0, 0);
        drive(0, 1, 2'b10, r3, 16'd0, 1);
        expect_word("min", pack('{2, 3, 1, 2, 1, 1, 4, 2}, 256), '0);

        // ADD with negatives, then clear+snap reporting the pre-clear ADD sum
        drive(1, 1, 2'b11, pack('{-3, 100, -200, 7, 0, 32767, -32768, 5}, 1), 16'd0, 0);
        drive(0, 1, 2'b11, pack('{1, -50, 300, 7, -1, 32767, -32768, -9}, 1), 16'd0, 0);
        drive(1, 1, 2'b00, ramp, 16'd256, 1);
        wait_cycles(4);
        drive(0, 0, 2'b00, '0, 16'd0, 1);
        wait_cycles(4);

        // saturation both directions
        drive(1, 1, 2'b00, pos, 16'(127*256), 0);
        drive(0, 1, 2'b00, pos, 16'(127*256), 0);
        drive(0, 1, 2'b00, pos, 16'(127*256), 1);
        expect_word("sat_pos", {NP{16'h7fff}}, '1);
        drive(1, 1, 2'b00, neg, 16'(127*256), 0);
        drive(0, 1, 2'b00, neg, 16'(127*256), 0);
        drive(0, 1, 2'b00, neg, 16'(127*256), 1);
        expect_word("sat_neg", {NP{16'h8000}}, '1);
        wait_cycles(1);

        // backpressure: second snapshot dropped while first is held
        out_ready = 0;
        drive(1, 1, 2'b11, ramp, 16'd0, 1);
        wait_cycles(2);
        check("bp_valid", W'(out_valid), W'(1));
        held = exp_q[0].word;
        wait_cycles(5);
        drop_next = 1;
        drive(0, 1, 2'b11, ramp, 16'd0, 1);
        wait_cycles(3);
        check("bp_overflow", W'(overflow), W'(1));
        check("bp_held", wordp, held);
        out_ready = 1;
        @(posedge clk); #1;
        check("bp_release", W'(out_valid), W'(0));

        // async reset in the middle of a MAC with a snapshot in flight
        drive(1, 1, 2'b00, ramp, 16'd256, 0);
        drive(0, 1, 2'b00, ramp, 16'd256, 1);
        #3 rst_n = 0;
        #1;
        check("arst_outs", {srca_word_d, wordp}, '0);
        check("arst_flags", W'({clr_d, we_d, sat, out_valid, overflow}), W'(0));
        model_reset();
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        drive(0, 0, 2'b00, '0, 16'd0, 1);
        expect_word("arst_snap", '0, '0);

        wait_cycles(4);
        check("queue_empty", W'(exp_q.size()), W'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
